pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PAY_W, default 106, payload width (EX/MEM packing: zero 1 + ALU result 32 + instruction 32 + store data 32 + dest reg 5 + ctrl 4).
REQ-002 Parameter ZERO_BUBBLE, default 1, when 1 the payload register is zeroed whenever the stage becomes empty.
REQ-003 Parameter CNT_W, default 16, width of the stall counter.
REQ-004 clk  input  1  single clock, all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous discard of all held entries.
REQ-007 in_valid  input  1  upstream presents a payload.
REQ-008 in_data  input  PAY_W  upstream payload.
REQ-009 in_ready  output  1  stage can accept a payload this cycle.
REQ-010 out_valid  output  1  out_data holds a valid payload.
REQ-011 out_data  output  PAY_W  payload to downstream.
REQ-012 out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 occupancy  output  2  entries held (0, 1 or 2).
REQ-014 stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Storage SHALL be a main register (drives out_data) plus one skid register; out_data SHALL come straight from the main register, with no combinational path from in_data.
REQ-016 State SHALL be EMPTY (occupancy 0), ONE (1) or TWO (2); out_valid = (state != EMPTY); in_ready = (state != TWO); both SHALL decode from registered state only.
REQ-017 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 EMPTY: accept -> main <= in_data, go ONE; else stay.
REQ-019 ONE: accept & pop -> main <= in_data, stay ONE; accept & !pop -> skid <= in_data, go TWO; !accept & pop -> go EMPTY; neither -> hold.
REQ-020 TWO: in_data ignored; pop -> main <= skid, go ONE; no pop -> hold.
REQ-021 Latency SHALL be 1 cycle from accept to out_valid in EMPTY; payload order SHALL be strictly FIFO, with no loss or duplication.
REQ-022 flush=1 SHALL force state EMPTY at the next edge, overriding any same-cycle accept or pop; an input offered during flush is dropped even though in_ready was 1.
REQ-023 With ZERO_BUBBLE=1, the main and skid registers SHALL be written with zero on every transition into EMPTY (pop-to-empty or flush). With ZERO_BUBBLE=0 they hold stale data.
REQ-024 stall_cnt SHALL increment by 1 each cycle with out_valid & !out_ready, SHALL saturate at 2^CNT_W-1, and is cleared only by reset; flush does not clear it.
REQ-025 Payload bits SHALL pass unmodified; no field inside PAY_W is interpreted.

Reset
REQ-026 reset=1 SHALL immediately, independent of clk, force state EMPTY, main=0, skid=0, stall_cnt=0; hence out_valid=0, in_ready=1, occupancy=0, out_data=0.
REQ-027 Reset asserted mid-transfer SHALL discard all held entries; the first edge after deassertion behaves as EMPTY.

Verification
REQ-028 Reset, then in_valid=1 with in_data=0x...A5 and out_ready=1 held -> out_valid=1 and out_data=0x...A5 one edge later; continuous streaming 1 item/cycle, in_ready stays 1.
REQ-029 Offer A, B, C on consecutive cycles with out_ready=0 -> A in main, B in skid, occupancy=2, in_ready=0, C not accepted; raise out_ready for 2 cycles -> out_data A then B, occupancy 2->1->0.
REQ-030 Hold occupancy=1 with out_ready=0 for 5 cycles -> stall_cnt=5; with CNT_W=3 and 10 stall cycles -> stall_cnt=7.
REQ-031 Occupancy=2, assert flush with in_valid=1 and data D -> next cycle occupancy=0, out_valid=0, out_data=0 (ZERO_BUBBLE=1); D never appears at out_data.
REQ-032 Assert reset asynchronously between edges while occupancy=2 -> out_valid, occupancy and out_data drop to 0 before the next edge; stall_cnt=0.
REQ-033 Random valid/ready traffic, 10k cycles, scoreboard -> output sequence equals accepted input sequence, and out_data never changes while out_valid=1 and out_ready=0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage: out_data comes straight from a register,
// in_ready and out_valid decode from registered state only, so no combinational path crosses the stage.
module pipe_stage_reg #(
   parameter int PAY_W       = 106,
   parameter int ZERO_BUBBLE = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [PAY_W-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [PAY_W-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } stateT;

   stateT            state;
   logic [PAY_W-1:0] mainReg;
   logic [PAY_W-1:0] skidReg;
   logic [CNT_W-1:0] stallCnt;
   logic             accept;
   logic             pop;
   logic             zeroOnEmpty;

   assign zeroOnEmpty = (ZERO_BUBBLE != 0);

   assign out_valid = (state != EMPTY);
   assign in_ready  = (state != TWO);
   assign occupancy = state;
   assign out_data  = mainReg;
   assign stall_cnt = stallCnt;

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   // NOTE: the payload registers are only two words, so they are cleared by reset like the state;
   // no large memory is involved here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= EMPTY;
         mainReg <= '0;
         skidReg <= '0;
      end else if (flush) begin
         // Flush beats any same-cycle accept or pop; the offered word is dropped.
         state <= EMPTY;
         if (zeroOnEmpty) begin
            mainReg <= '0;
            skidReg <= '0;
         end
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  mainReg <= in_data;
                  state   <= ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  mainReg <= in_data;
               end else if (accept) begin
                  skidReg <= in_data;
                  state   <= TWO;
               end else if (pop) begin
                  state <= EMPTY;
                  if (zeroOnEmpty) begin
                     mainReg <= '0;
                     skidReg <= '0;
                  end
               end
            end
            TWO: begin
               // in_ready is low here, so in_data is never looked at.
               if (pop) begin
                  mainReg <= skidReg;
                  state   <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

   // Saturating stall counter; only reset clears it, flush leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stallCnt <= '0;
      end else if (out_valid && !out_ready && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg; a second instance (CNT_W=3, ZERO_BUBBLE=0)
// shares the inputs to cover stall saturation and stale-data behaviour.
module tb_pipe_stage_reg;

   localparam int W = 106;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         flush = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         out_ready = 1'b0;

   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   occupancy;
   logic [15:0]  stall_cnt;

   logic         inReady2, outValid2;
   logic [W-1:0] outData2;
   logic [1:0]   occupancy2;
   logic [2:0]   stallCnt2;

   int checks = 0;
   int errors = 0;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_reg #(.PAY_W(W), .ZERO_BUBBLE(0), .CNT_W(3)) dut2 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(inReady2),
      .out_valid(outValid2), .out_data(outData2), .out_ready(out_ready),
      .occupancy(occupancy2), .stall_cnt(stallCnt2)
   );

   always #5 clk = ~clk;

   // Payload with low byte b and non-zero upper bits so the full width is exercised.
   function automatic logic [W-1:0] mk(input logic [7:0] b);
      mk = {{12{8'h3C}}, 2'b01, b};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      doReset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
   endtask

   task automatic test_stream();
      logic [W-1:0] last;
      doReset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         last = mk(8'hA5 + 8'(i));
         in_data = last;
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
         checks++; if (out_data !== last) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, out_data, last); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %0b want 1", i, in_ready); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d want 1", i, occupancy); end
      end
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL drain_zero_bubble got %h want 0", out_data); end
      checks++; if (outData2 !== last) begin errors++; $display("FAIL drain_stale got %h want %h", outData2, last); end
   endtask

   task automatic test_skid();
      doReset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(8'h0A); tick();
      in_data = mk(8'h0B); tick();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_occ got %0d want 2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready got %0b want 0", in_ready); end
      checks++; if (out_data !== mk(8'h0A)) begin errors++; $display("FAIL skid_main got %h want %h", out_data, mk(8'h0A)); end
      in_data = mk(8'h0C); tick();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL skid_c_refused_occ got %0d want 2", occupancy); end
      checks++; if (out_data !== mk(8'h0A)) begin errors++; $display("FAIL skid_hold got %h want %h", out_data, mk(8'h0A)); end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      checks++; if (out_data !== mk(8'h0B)) begin errors++; $display("FAIL skid_pop_b got %h want %h", out_data, mk(8'h0B)); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL skid_occ1 got %0d want 1", occupancy); end
      tick();
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL skid_occ0 got %0d want 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL skid_no_c got %0b want 0", out_valid); end
   endtask

   task automatic test_stall();
      doReset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(8'h55);
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall5 got %0d want 5", stall_cnt); end
      checks++; if (stallCnt2 !== 3'd5) begin errors++; $display("FAIL stall5_w3 got %0d want 5", stallCnt2); end
      repeat (5) tick();
      checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall10 got %0d want 10", stall_cnt); end
      checks++; if (stallCnt2 !== 3'd7) begin errors++; $display("FAIL stall_sat_w3 got %0d want 7", stallCnt2); end
      checks++; if (occupancy2 !== 2'd1 || outValid2 !== 1'b1) begin errors++; $display("FAIL stall_dut2_state got occ %0d valid %0b want 1 1", occupancy2, outValid2); end
      checks++; if (out_data !== mk(8'h55)) begin errors++; $display("FAIL stall_hold got %h want %h", out_data, mk(8'h55)); end
   endtask

   task automatic test_flush();
      doReset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(8'h0A); tick();
      in_data = mk(8'h0B); tick();
      flush = 1'b1;
      out_ready = 1'b1;
      in_data = mk(8'hDD);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", occupancy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_zero got %h want 0", out_data); end
      checks++; if (outData2 !== mk(8'h0A)) begin errors++; $display("FAIL flush_stale got %h want %h", outData2, mk(8'h0A)); end
      checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_keeps_stall got %0d want 1", stall_cnt); end
      checks++; if (inReady2 !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", inReady2); end
      repeat (3) begin
         tick();
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_d_leaked got valid %0b data %h want 0", out_valid, out_data); end
      end
   endtask

   task automatic test_async_reset();
      doReset();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = mk(8'h0A); tick();
      in_data = mk(8'h0B); tick();
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL async_state got valid %0b occ %0d want 0 0", out_valid, occupancy); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL async_data got %h want 0", out_data); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL async_stall got %0d want 0", stall_cnt); end
      #1 reset = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = mk(8'hEE);
      tick();
      in_valid = 1'b0;
      checks++; if (occupancy !== 2'd1 || out_data !== mk(8'hEE)) begin errors++; $display("FAIL post_reset got occ %0d data %h want 1 %h", occupancy, out_data, mk(8'hEE)); end
   endtask

   task automatic test_random();
      logic [W-1:0] q[$];
      logic [W-1:0] prevData;
      logic [127:0] r;
      logic         acc, pop, prevStall;
      doReset();
      prevStall = 1'b0;
      prevData = '0;
      for (int c = 0; c < 10000; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         r = {$urandom, $urandom, $urandom, $urandom};
         in_data = r[W-1:0];
         #1;
         checks++; if (occupancy !== 2'(q.size())) begin errors++; $display("FAIL rand_occ cyc %0d got %0d want %0d", c, occupancy, q.size()); end
         if (q.size() != 0) begin
            checks++; if (out_data !== q[0]) begin errors++; $display("FAIL rand_order cyc %0d got %h want %h", c, out_data, q[0]); end
         end
         if (prevStall) begin
            checks++; if (out_data !== prevData) begin errors++; $display("FAIL rand_stable cyc %0d got %h want %h", c, out_data, prevData); end
         end
         acc = in_valid & (q.size() < 2);
         pop = out_ready & (q.size() != 0);
         prevStall = (q.size() != 0) & ~out_ready;
         prevData = out_data;
         tick();
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(in_data);
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_skid();
      test_stall();
      test_flush();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
